// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// A pixel-rate divider on Clk drives horizontal/vertical counters. All sync,
// blank and strobe outputs are registered from next-state counter values so
// they change on the same Clk edge as DrawX/DrawY. run=0 freezes everything.
// Reset_n is asserted asynchronously. Its release is expected to come already
// aligned to Clk from the system two-flop reset synchroniser.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 2,
    parameter int COORD_W  = 10
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               run,
    output logic               pixel_clk,
    output logic               pix_en,
    output logic               hs,
    output logic               vs,
    output logic               blank_n,
    output logic               sync_n,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int D_W     = $clog2(CLK_DIV);

    localparam logic [D_W-1:0]     D_LAST   = D_W'(CLK_DIV - 1);
    localparam logic [D_W-1:0]     D_HALF   = D_W'(CLK_DIV / 2);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic               HS_ON    = (HS_POL != 0);
    localparam logic               VS_ON    = (VS_POL != 0);

    logic [D_W-1:0]     d_q, d_d;
    logic [COORD_W-1:0] hc_q, hc_d;
    logic [COORD_W-1:0] vc_q, vc_d;
    logic               pix_en_q, pix_en_d;
    logic               pclk_q, pclk_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               blank_n_q, blank_n_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic               h_wrap, v_wrap;

    // Next-state: divider, counters, and the levels/strobes they imply.
    always_comb begin
        pix_en_d = run && (d_q == D_LAST);
        h_wrap   = pix_en_d && (hc_q == H_LAST);
        v_wrap   = h_wrap && (vc_q == V_LAST);

        d_d = d_q;
        if (run) begin
            d_d = pix_en_d ? '0 : d_q + 1'b1;
        end

        hc_d = hc_q;
        vc_d = vc_q;
        if (pix_en_d) begin
            hc_d = h_wrap ? '0 : hc_q + 1'b1;
        end
        if (h_wrap) begin
            vc_d = v_wrap ? '0 : vc_q + 1'b1;
        end

        pclk_d        = (d_d >= D_HALF);
        hs_d          = ((hc_d >= HS_FIRST) && (hc_d <= HS_LAST)) ? HS_ON : !HS_ON;
        vs_d          = ((vc_d >= VS_FIRST) && (vc_d <= VS_LAST)) ? VS_ON : !VS_ON;
        blank_n_d     = (hc_d < H_ACT_C) && (vc_d < V_ACT_C);
        line_start_d  = h_wrap;
        frame_start_d = v_wrap;
    end

    // State and output registers; reset parks the raster on the last pixel
    // so the first pixel after release wraps to (0,0) with a frame strobe.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            d_q           <= '0;
            hc_q          <= H_LAST;
            vc_q          <= V_LAST;
            pix_en_q      <= 1'b0;
            pclk_q        <= 1'b0;
            hs_q          <= !HS_ON;
            vs_q          <= !VS_ON;
            blank_n_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            d_q           <= d_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            pix_en_q      <= pix_en_d;
            pclk_q        <= pclk_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_n_q     <= blank_n_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_clk   = pclk_q;
    assign pix_en      = pix_en_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank_n     = blank_n_q;
    assign sync_n      = 1'b0;
    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen, one default-timing
// instance and one small-raster instance (CLK_DIV=4, positive syncs).
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic Reset_n;
    logic run;

    always #5 clk = ~clk;

    logic       d_pixel_clk, d_pix_en, d_hs, d_vs, d_blank_n, d_sync_n;
    logic       d_line_start, d_frame_start;
    logic [9:0] d_drawx, d_drawy;

    logic       s_pixel_clk, s_pix_en, s_hs, s_vs, s_blank_n, s_sync_n;
    logic       s_line_start, s_frame_start;
    logic [3:0] s_drawx, s_drawy;

    int n_vec = 0;
    int n_err = 0;

    vga_timing_gen u_def (
        .Clk         (clk),
        .Reset_n     (Reset_n),
        .run         (run),
        .pixel_clk   (d_pixel_clk),
        .pix_en      (d_pix_en),
        .hs          (d_hs),
        .vs          (d_vs),
        .blank_n     (d_blank_n),
        .sync_n      (d_sync_n),
        .DrawX       (d_drawx),
        .DrawY       (d_drawy),
        .line_start  (d_line_start),
        .frame_start (d_frame_start)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .CLK_DIV(4), .COORD_W(4)
    ) u_sml (
        .Clk         (clk),
        .Reset_n     (Reset_n),
        .run         (run),
        .pixel_clk   (s_pixel_clk),
        .pix_en      (s_pix_en),
        .hs          (s_hs),
        .vs          (s_vs),
        .blank_n     (s_blank_n),
        .sync_n      (s_sync_n),
        .DrawX       (s_drawx),
        .DrawY       (s_drawy),
        .line_start  (s_line_start),
        .frame_start (s_frame_start)
    );

    // Reset values, then the first pixel two Clk after release is a frame start.
    task automatic test_reset();
        run     = 1'b1;
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (d_drawx !== 10'd799 || d_drawy !== 10'd524) begin
            n_err++;
            $display("FAIL reset_def_coords: got %0d/%0d want 799/524", d_drawx, d_drawy);
        end
        n_vec++;
        if ({d_hs, d_vs, d_blank_n, d_sync_n, d_pixel_clk, d_pix_en, d_line_start, d_frame_start} !== 8'b1100_0000) begin
            n_err++;
            $display("FAIL reset_def_flags: got %b want 11000000",
                     {d_hs, d_vs, d_blank_n, d_sync_n, d_pixel_clk, d_pix_en, d_line_start, d_frame_start});
        end
        n_vec++;
        if (s_drawx !== 4'd13 || s_drawy !== 4'd6 ||
            {s_hs, s_vs, s_blank_n, s_sync_n, s_pixel_clk, s_pix_en, s_line_start, s_frame_start} !== 8'b0000_0000) begin
            n_err++;
            $display("FAIL reset_sml: got x=%0d y=%0d flags=%b want 13/6 00000000", s_drawx, s_drawy,
                     {s_hs, s_vs, s_blank_n, s_sync_n, s_pixel_clk, s_pix_en, s_line_start, s_frame_start});
        end
        Reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (d_frame_start !== 1'b0 || d_pix_en !== 1'b0 || d_pixel_clk !== 1'b1) begin
            n_err++;
            $display("FAIL release_cycle1: got fs=%b pe=%b pclk=%b want 0 0 1", d_frame_start, d_pix_en, d_pixel_clk);
        end
        @(negedge clk);
        n_vec++;
        if ({d_frame_start, d_line_start, d_pix_en, d_blank_n, d_hs, d_vs, d_pixel_clk} !== 7'b1111110 ||
            d_drawx !== 10'd0 || d_drawy !== 10'd0) begin
            n_err++;
            $display("FAIL release_cycle2: got fs/ls/pe/bn/hs/vs/pclk=%b x=%0d y=%0d want 1111110 0 0",
                     {d_frame_start, d_line_start, d_pix_en, d_blank_n, d_hs, d_vs, d_pixel_clk}, d_drawx, d_drawy);
        end
    endtask

    // One full default line from the frame-start sample.
    task automatic test_line_scan();
        int x_err = 0, pe_err = 0, pc_err = 0, ls_err = 0;
        int pe_cnt = 0, hs_cnt = 0, hs_first = -1, hs_last = -1;
        int bl_cnt = 0, bl_first = -1, bl_last = -1, x_max = 0;
        for (int i = 1; i <= 1600; i++) begin
            @(negedge clk);
            if (int'(d_drawx) != (i / 2) % 800 || int'(d_drawy) != ((i == 1600) ? 1 : 0)) x_err++;
            if (d_pix_en !== ((i % 2) == 0)) pe_err++;
            if (d_pixel_clk !== ((i % 2) == 1)) pc_err++;
            if (d_line_start !== (i == 1600) || d_frame_start !== 1'b0) ls_err++;
            if (d_pix_en === 1'b1) pe_cnt++;
            if (int'(d_drawx) > x_max) x_max = int'(d_drawx);
            if (d_hs === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(d_drawx);
                hs_last = int'(d_drawx);
            end
            if (d_blank_n === 1'b0) begin
                bl_cnt++;
                if (bl_first < 0) bl_first = int'(d_drawx);
                bl_last = int'(d_drawx);
            end
        end
        n_vec++;
        if (x_err != 0) begin n_err++; $display("FAIL line_coords: %0d bad cycles, want 0", x_err); end
        n_vec++;
        if (pe_err != 0 || pe_cnt != 800) begin
            n_err++; $display("FAIL line_pix_en: bad=%0d count=%0d want 0 800", pe_err, pe_cnt);
        end
        n_vec++;
        if (pc_err != 0) begin n_err++; $display("FAIL line_pixel_clk: %0d bad cycles, want 0", pc_err); end
        n_vec++;
        if (ls_err != 0) begin n_err++; $display("FAIL line_strobes: %0d bad cycles, want 0", ls_err); end
        n_vec++;
        if (hs_cnt != 192 || hs_first != 656 || hs_last != 751) begin
            n_err++; $display("FAIL line_hs: cnt=%0d span=%0d..%0d want 192 656..751", hs_cnt, hs_first, hs_last);
        end
        n_vec++;
        if (bl_cnt != 320 || bl_first != 640 || bl_last != 799) begin
            n_err++; $display("FAIL line_blank: cnt=%0d span=%0d..%0d want 320 640..799", bl_cnt, bl_first, bl_last);
        end
        n_vec++;
        if (x_max != 799) begin n_err++; $display("FAIL line_x_max: got %0d want 799", x_max); end
    endtask

    // Freeze for 50 Clk at DrawX=300, then drop run on a would-be pix_en at 400.
    task automatic test_pause();
        int k = 0, p_err = 0;
        bit got = 0, did1 = 0, did2 = 0;
        while (!got && k < 4000) begin
            @(negedge clk);
            k++;
            if (d_line_start === 1'b1) begin
                got = 1;
            end else if (!did1 && d_drawx === 10'd300 && d_pix_en === 1'b1) begin
                did1 = 1;
                run  = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    k++;
                    if (d_drawx !== 10'd300 || d_pix_en !== 1'b0 || d_line_start !== 1'b0 || d_pixel_clk !== 1'b0) p_err++;
                end
                run = 1'b1;
                n_vec++;
                if (p_err != 0) begin n_err++; $display("FAIL pause_hold: %0d bad cycles, want 0", p_err); end
                @(negedge clk);
                k++;
                @(negedge clk);
                k++;
                n_vec++;
                if (d_drawx !== 10'd301 || d_pix_en !== 1'b1) begin
                    n_err++; $display("FAIL pause_resume: got x=%0d pe=%b want 301 1", d_drawx, d_pix_en);
                end
            end else if (did1 && !did2 && d_drawx === 10'd400 && d_pix_en === 1'b0) begin
                did2 = 1;
                run  = 1'b0;
                @(negedge clk);
                k++;
                n_vec++;
                if (d_drawx !== 10'd400 || d_pix_en !== 1'b0) begin
                    n_err++; $display("FAIL suppress_hold: got x=%0d pe=%b want 400 0", d_drawx, d_pix_en);
                end
                run = 1'b1;
                @(negedge clk);
                k++;
                n_vec++;
                if (d_drawx !== 10'd401 || d_pix_en !== 1'b1) begin
                    n_err++; $display("FAIL suppress_resume: got x=%0d pe=%b want 401 1", d_drawx, d_pix_en);
                end
            end
        end
        n_vec++;
        if (!got || !did1 || !did2 || k != 1651 || d_drawy !== 10'd2) begin
            n_err++;
            $display("FAIL pause_line_period: got k=%0d seen=%0d%0d%0d y=%0d want 1651 111 2",
                     k, got, did1, did2, d_drawy);
        end
    endtask

    // Async reset mid-line, then frame start two Clk after release.
    task automatic test_reset_mid();
        int k = 0;
        while (d_drawx !== 10'd100 && k < 400) begin
            @(negedge clk);
            k++;
        end
        #2 Reset_n = 1'b0;
        #1;
        n_vec++;
        if (d_drawx !== 10'd799 || d_drawy !== 10'd524 || s_drawx !== 4'd13 || s_drawy !== 4'd6 ||
            {d_hs, d_vs, d_blank_n, d_pix_en, d_line_start, d_frame_start} !== 6'b110000) begin
            n_err++;
            $display("FAIL mid_reset_async: got x=%0d y=%0d sx=%0d sy=%0d flags=%b want 799 524 13 6 110000",
                     d_drawx, d_drawy, s_drawx, s_drawy,
                     {d_hs, d_vs, d_blank_n, d_pix_en, d_line_start, d_frame_start});
        end
        @(negedge clk);
        n_vec++;
        if (d_frame_start !== 1'b0 || d_line_start !== 1'b0 || d_drawx !== 10'd799) begin
            n_err++; $display("FAIL mid_reset_hold: got fs=%b ls=%b x=%0d want 0 0 799", d_frame_start, d_line_start, d_drawx);
        end
        Reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (d_frame_start !== 1'b0) begin n_err++; $display("FAIL mid_release_c1: got fs=%b want 0", d_frame_start); end
        @(negedge clk);
        n_vec++;
        if (d_frame_start !== 1'b1 || d_drawx !== 10'd0 || d_drawy !== 10'd0) begin
            n_err++; $display("FAIL mid_release_c2: got fs=%b x=%0d y=%0d want 1 0 0", d_frame_start, d_drawx, d_drawy);
        end
    endtask

    // Small raster, two full frames; j counts Clk since the last reset release.
    task automatic test_small();
        int pc_err = 0, pe_err = 0, xy_err = 0, st_err = 0, lv_err = 0;
        int fs_cnt = 0, fs_prev = -1, fs_gap = 0, hs_cnt = 0, x_max = 0, y_max = 0;
        for (int j = 3; j <= 800; j++) begin
            int p, ex, ey;
            @(negedge clk);
            p  = (j - 4) / 4;
            ex = (j < 4) ? 13 : p % 14;
            ey = (j < 4) ? 6 : (p / 14) % 7;
            if (s_pixel_clk !== ((j % 4) >= 2)) pc_err++;
            if (s_pix_en !== ((j % 4) == 0)) pe_err++;
            if (int'(s_drawx) != ex || int'(s_drawy) != ey) xy_err++;
            if (s_frame_start !== (j >= 4 && (j - 4) % 392 == 0) ||
                s_line_start !== (j >= 4 && (j - 4) % 56 == 0)) st_err++;
            if (s_hs !== (ex >= 10 && ex <= 11) || s_vs !== (ey == 5) ||
                s_blank_n !== (ex < 8 && ey < 4) || s_sync_n !== 1'b0) lv_err++;
            if (s_hs === 1'b1) hs_cnt++;
            if (int'(s_drawx) > x_max) x_max = int'(s_drawx);
            if (int'(s_drawy) > y_max) y_max = int'(s_drawy);
            if (s_frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_prev >= 0) fs_gap = j - fs_prev;
                fs_prev = j;
            end
        end
        n_vec++;
        if (pc_err != 0) begin n_err++; $display("FAIL sml_pixel_clk: %0d bad cycles, want 0", pc_err); end
        n_vec++;
        if (pe_err != 0) begin n_err++; $display("FAIL sml_pix_en: %0d bad cycles, want 0", pe_err); end
        n_vec++;
        if (xy_err != 0) begin n_err++; $display("FAIL sml_coords: %0d bad cycles, want 0", xy_err); end
        n_vec++;
        if (st_err != 0) begin n_err++; $display("FAIL sml_strobes: %0d bad cycles, want 0", st_err); end
        n_vec++;
        if (lv_err != 0) begin n_err++; $display("FAIL sml_levels: %0d bad cycles, want 0", lv_err); end
        n_vec++;
        if (fs_cnt != 3 || fs_gap != 392) begin
            n_err++; $display("FAIL sml_frame_period: cnt=%0d gap=%0d want 3 392", fs_cnt, fs_gap);
        end
        n_vec++;
        if (hs_cnt != 112 || x_max != 13 || y_max != 6) begin
            n_err++; $display("FAIL sml_bounds: hs_cnt=%0d xmax=%0d ymax=%0d want 112 13 6", hs_cnt, x_max, y_max);
        end
    endtask

    initial begin
        test_reset();
        test_line_scan();
        test_pause();
        test_reset_mid();
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case a wait never resolves.
    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running at 1 ms, want finished");
        $fatal(1, "timeout");
    end

endmodule
